ram_bus_master: RTL and testbench
=================================

# ram_bus_master

Initiator for the shared 16-bit tri-state Bus that owns the 256-word RAM. It accepts burst read/write requests from a client over valid/ready handshakes and arbitrates for the Bus via BusReq/BusGnt. It drives AddressOut, RamIn, RamOut and Bus to the RAM's AddressIn/RamIn/RamOut/Bus pins, and returns read data through a one-entry output buffer. It lets a DMA-style client move data in and out of RAM without the CPU control unit sequencing every word.

## Interface
- ADDR_W, 8, RAM word-address width
- DATA_W, 16, Bus and RAM word width
- LEN_W, 4, burst length field width; a burst is ReqLen+1 words, 1..16
- Clk  in  1  system clock; RAM samples on the falling edge
- Rst  in  1  asynchronous, active-low reset
- BusReq  out  1  request Bus ownership
- BusGnt  in  1  Bus granted to this block; may drop at any cycle
- Bus  inout  DATA_W  shared bus; driven only during a write beat, otherwise Hi-Z
- AddressOut  out  ADDR_W  RAM word address
- RamIn  out  1  RAM write strobe, one per write beat
- RamOut  out  1  RAM output enable, one per read beat
- ReqValid / ReqReady  in / out  1  request handshake
- ReqWrite  in  1  1 = write burst, 0 = read burst
- ReqAddr  in  ADDR_W  start address
- ReqLen  in  LEN_W  words minus one
- WrValid / WrReady / WrData  in / out / in  1/1/DATA_W  write-data stream
- RdValid / RdReady / RdData  out / in / out  1/1/DATA_W  read-data stream
- Busy  out  1  state != IDLE
- Err  out  1  one-cycle pulse on a rejected request

## Operation
- Reset values: BusReq, RamIn, RamOut, WrReady, RdValid, Busy and Err are 0. AddressOut and RdData are 0. Bus is Hi-Z. The state is IDLE.
- The FSM has three states: IDLE, ARB and XFER.
- IDLE:
  - ReqReady = !RdValid.
  - On accept, latch the address, the beat counter (ReqLen) and the direction, then go to ARB.
- ARB:
  - BusReq = 1.
  - Move to XFER on the edge where BusGnt is sampled 1.
- XFER:
  - BusReq = 1.
  - A beat issues only while BusGnt = 1.
  - Write beat: WrReady = BusGnt. When WrValid && BusGnt, RamIn = 1 and Bus = WrData, both combinational, with AddressOut = current address.
  - Read beat: issues when BusGnt && (!RdValid || RdReady). RamOut = 1 and AddressOut = current address. Bus is sampled into RdData at the rising edge ending the beat, and RdValid is set.
  - After each beat: address += 1 and counter -= 1.
  - After the beat with counter = 0, go to IDLE. BusReq drops in the same edge.
- If BusGnt drops mid-burst, the FSM pauses in XFER: no strobes, Bus Hi-Z, BusReq held. It resumes when BusGnt returns, with no beat lost or repeated.
- RdValid clears on RdReady unless a new read beat refills the buffer in the same cycle.
- Reset asserted mid-burst: all outputs return to reset values immediately (async), Bus is released, and the buffered read data is discarded.
- RamIn and RamOut are never asserted together.

## Timing
- Accept at edge 0. BusReq is high in cycle 1 (ARB).
- If BusGnt = 1 in cycle 1, the first beat is in cycle 2.
- Single-word write, client ready: RamIn high for exactly cycle 2. The RAM is written on the falling edge inside cycle 2. BusReq is low from cycle 3.
- Single-word read: RamOut high in cycle 2. RdValid = 1 with data from cycle 3.
- Unstalled bursts sustain 1 word/cycle.
- Address arithmetic is modulo 2^ADDR_W. The overflow check uses an ADDR_W+1-bit sum, ReqAddr + ReqLen.

## Configuration
- RAM_BUS_MASTER_WRAP_EN defined: a burst crossing 0xFF wraps to 0x00 and is executed.
- Undefined: a request with ReqAddr + ReqLen > 0xFF is still handshaked (ReqReady/ReqValid complete). Err pulses in the following cycle, the FSM stays IDLE, and no Bus activity occurs.

## Structure
- Shared package ram_bus_pkg:
  - FSM state encoding constants ST_IDLE, ST_ARB, ST_XFER
  - ADDR_W, DATA_W and LEN_W defaults
  - RAM_DEPTH = 256
- Sub-module ram_rd_buffer: one-entry valid/ready holding register for read data, with simultaneous load/drain support.

## Test plan
- Write burst of 4 to 0x10 (data 0xA000..0xA003), BusGnt held high: RamIn high for 4 consecutive cycles with AddressOut 0x10..0x13; Bus Hi-Z before and after; BusReq low after the last beat.
- Read burst of 4 from 0x10 with RdReady = 1: RdData 0xA000..0xA003 on 4 consecutive cycles; RamIn never asserted.
- Read burst of 3 with RdReady low for 2 cycles after the first word: RamOut pauses, and no word is lost or duplicated.
- BusGnt dropped for 3 cycles mid-write at beat 2 of 5: Bus Hi-Z and strobes low during the gap; beats resume at the correct address; exactly 5 RamIn pulses total.
- Request at ReqAddr 0xFE with ReqLen 3: with WRAP_EN, addresses are 0xFE, 0xFF, 0x00, 0x01; without it, one Err pulse and no RamIn/RamOut.
- Rst pulsed low during beat 2 of a write burst: Bus goes Hi-Z and BusReq goes low immediately; after release, Busy = 0 and ReqReady = 1.

Source files
------------

// File: rtl/ram_bus_pkg.sv
// ---------------------------------------------------------------------------
// ram_bus_pkg
// Shared definitions for the RAM bus master slice.
//   ADDR_W / DATA_W / LEN_W : address, data and burst-length field widths
//   RAM_DEPTH               : number of words behind the shared Bus
//   state_t                 : FSM encoding (ST_IDLE, ST_ARB, ST_XFER)
//   burstOverflows()        : true when a burst would run past the top word
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package ram_bus_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 16;
  localparam int LEN_W     = 4;
  localparam int RAM_DEPTH = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  // The sum is one bit wider than the address, so the carry bit says whether
  // the last word of the burst lies beyond the top of the RAM.
  function automatic logic burstOverflows(input logic [ADDR_W-1:0] addr,
                                          input logic [LEN_W-1:0]  len);
    logic [ADDR_W:0] sum;
    sum = {1'b0, addr} + {{(ADDR_W + 1 - LEN_W){1'b0}}, len};
    return sum[ADDR_W];
  endfunction

endpackage

// File: rtl/ram_bus_master_if.sv
// ---------------------------------------------------------------------------
// ram_bus_master_if
// Groups the request, write-data, read-data, arbitration and RAM strobe
// signals of the bus master. The tri-state data Bus itself is not in here;
// it is a plain inout pin on the master.
//   modport master : the ram_bus_master side
//   modport slave  : the client / arbiter / RAM side
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface ram_bus_master_if;
  import ram_bus_pkg::*;

  logic              busReq;
  logic              busGnt;
  logic [ADDR_W-1:0] addressOut;
  logic              ramIn;
  logic              ramOut;
  logic              reqValid;
  logic              reqReady;
  logic              reqWrite;
  logic [ADDR_W-1:0] reqAddr;
  logic [LEN_W-1:0]  reqLen;
  logic              wrValid;
  logic              wrReady;
  logic [DATA_W-1:0] wrData;
  logic              rdValid;
  logic              rdReady;
  logic [DATA_W-1:0] rdData;
  logic              busy;
  logic              err;

  modport master (
    output busReq, addressOut, ramIn, ramOut, reqReady, wrReady,
           rdValid, rdData, busy, err,
    input  busGnt, reqValid, reqWrite, reqAddr, reqLen, wrValid, wrData,
           rdReady
  );

  modport slave (
    input  busReq, addressOut, ramIn, ramOut, reqReady, wrReady,
           rdValid, rdData, busy, err,
    output busGnt, reqValid, reqWrite, reqAddr, reqLen, wrValid, wrData,
           rdReady
  );

endinterface

// File: rtl/ram_rd_buffer.sv
// ---------------------------------------------------------------------------
// ram_rd_buffer
// One-entry valid/ready holding register for read data. A load in the same
// cycle as a drain keeps the entry valid with the new word.
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : capture data_i at this rising edge
//   data_i     : word sampled from the Bus
//   ready_i    : consumer accepts the held word
//   valid_o    : entry holds a word
//   data_o     : held word
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module ram_rd_buffer
  import ram_bus_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Load wins over drain so a refill in the drain cycle keeps the entry full.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Reset discards whatever word was being held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/ram_bus_master.sv
// ---------------------------------------------------------------------------
// ram_bus_master
// Burst initiator for the shared 16-bit tri-state Bus in front of the
// 256-word RAM. Takes burst requests from a client, arbitrates with
// BusReq/BusGnt, strobes the RAM one word per beat and returns read data
// through a one-entry buffer.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus_io     : shared data Bus, driven only during a write beat
//   bif        : master modport carrying request, write stream, read stream,
//                arbitration, RAM address/strobes, Busy and Err
// Build option RAM_BUS_MASTER_WRAP_EN: bursts crossing 0xFF wrap to 0x00.
// Without it such requests are handshaked, answered with an Err pulse and
// not executed.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module ram_bus_master
  import ram_bus_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  inout  wire  [DATA_W-1:0] bus_io,
  ram_bus_master_if.master  bif
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              write_q, write_d;
  logic              err_q, err_d;
  logic              reject;
  logic              beat;
  logic              busOe;
  logic              rdLoad;
  logic              rdValid;
  logic [DATA_W-1:0] rdData;

`ifdef RAM_BUS_MASTER_WRAP_EN
  assign reject = 1'b0;
`else
  assign reject = burstOverflows(bif.reqAddr, bif.reqLen);
`endif

  // Next-state and output decode. A beat only happens in XFER with the grant
  // held; losing the grant simply stalls the beat, so address and counter
  // stay put and the burst resumes on the same word.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    err_d        = 1'b0;
    beat         = 1'b0;
    busOe        = 1'b0;
    rdLoad       = 1'b0;
    bif.busReq   = 1'b0;
    bif.reqReady = 1'b0;
    bif.wrReady  = 1'b0;
    bif.ramIn    = 1'b0;
    bif.ramOut   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bif.reqReady = !rdValid;
        if (bif.reqValid && !rdValid) begin
          if (reject) begin
            err_d = 1'b1;
          end else begin
            addr_d  = bif.reqAddr;
            cnt_d   = bif.reqLen;
            write_d = bif.reqWrite;
            state_d = ST_ARB;
          end
        end
      end
      ST_ARB: begin
        bif.busReq = 1'b1;
        if (bif.busGnt) begin
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        bif.busReq = 1'b1;
        if (write_q) begin
          bif.wrReady = bif.busGnt;
          beat        = bif.wrValid && bif.busGnt;
          bif.ramIn   = beat;
          busOe       = beat;
        end else begin
          beat       = bif.busGnt && (!rdValid || bif.rdReady);
          bif.ramOut = beat;
          rdLoad     = beat;
        end
        if (beat) begin
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q - LEN_W'(1);
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and burst bookkeeping; reset drops everything back to IDLE so all
  // strobes and the Bus driver release immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      err_q   <= err_d;
    end
  end

  // The word on the Bus during a read beat is captured at the edge ending it.
  ram_rd_buffer u_rdBuffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (rdLoad),
    .data_i  (bus_io),
    .ready_i (bif.rdReady),
    .valid_o (rdValid),
    .data_o  (rdData)
  );

  assign bus_io         = busOe ? bif.wrData : {DATA_W{1'bz}};
  assign bif.addressOut = addr_q;
  assign bif.rdValid    = rdValid;
  assign bif.rdData     = rdData;
  assign bif.busy       = (state_q != ST_IDLE);
  assign bif.err        = err_q;

endmodule

// File: tb/tb_ram_bus_master.sv
// ---------------------------------------------------------------------------
// tb_ram_bus_master
// Self-checking bench for ram_bus_master. A RAM model sits on the Bus, and a
// keeper pulls the Bus to zero whenever neither strobe is active, so any
// stray drive from the master shows up as a nonzero Bus. Expected memory
// contents and read data come from a word-array model updated per burst.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ram_bus_master;
  import ram_bus_pkg::*;

  logic              clk;
  logic              rst_n;
  tri   [DATA_W-1:0] bus;

  ram_bus_master_if busIf ();

  ram_bus_master dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus),
    .bif    (busIf)
  );

  logic [DATA_W-1:0] mem    [RAM_DEPTH];
  logic [DATA_W-1:0] refMem [RAM_DEPTH];

  assign bus = busIf.ramOut ? mem[busIf.addressOut] : {DATA_W{1'bz}};
  assign bus = (!busIf.ramOut && !busIf.ramIn) ? {DATA_W{1'b0}} : {DATA_W{1'bz}};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;
  int cycleNo     = 0;

  logic [DATA_W-1:0] wrQueue[$];
  logic [DATA_W-1:0] rdGot[$];
  logic [ADDR_W-1:0] wrAddrLog[$];
  logic [ADDR_W-1:0] rdAddrLog[$];

  int ramInCount, ramOutCount, errCount;
  int overlapViol, hizViol, busDataViol, gntViol;
  int busReqFirst, busReqLast, ramInFirst, ramInLast, ramOutFirst;
  int rdValidFirst, rdTakeFirst, rdTakeLast, acceptCycle;
  bit reqTakenFlag;
  bit wrRandom, rdRandom, gntRandom;
  int rdStallArm, rdStallLeft, gntDropAfter, gntDropLen, gntStallLeft;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic clearLogs();
    rdGot.delete();
    wrAddrLog.delete();
    rdAddrLog.delete();
    ramInCount   = 0;
    ramOutCount  = 0;
    errCount     = 0;
    overlapViol  = 0;
    hizViol      = 0;
    busDataViol  = 0;
    gntViol      = 0;
    busReqFirst  = -1;
    busReqLast   = -1;
    ramInFirst   = -1;
    ramInLast    = -1;
    ramOutFirst  = -1;
    rdValidFirst = -1;
    rdTakeFirst  = -1;
    rdTakeLast   = -1;
    acceptCycle  = -1;
    reqTakenFlag = 1'b0;
    rdStallLeft  = 0;
    gntStallLeft = 0;
  endtask

  task automatic driveStreams();
    busIf.wrValid = (wrQueue.size() > 0) && (!wrRandom || ($urandom_range(3) != 0));
    busIf.wrData  = (wrQueue.size() > 0) ? wrQueue[0] : 16'hFFFF;
    if (rdStallLeft > 0) begin
      busIf.rdReady = 1'b0;
      rdStallLeft--;
    end else begin
      busIf.rdReady = rdRandom ? 1'($urandom_range(1)) : 1'b1;
    end
    if (gntStallLeft > 0) begin
      busIf.busGnt = 1'b0;
      gntStallLeft--;
    end else begin
      busIf.busGnt = gntRandom ? ($urandom_range(3) != 0) : 1'b1;
    end
  endtask

  task automatic stepCycle();
    bit wrTake, rdTake, reqTake;
    @(negedge clk);
    if (busIf.ramIn && busIf.ramOut) overlapViol++;
    if (!busIf.ramIn && !busIf.ramOut && bus !== {DATA_W{1'b0}}) hizViol++;
    if (!busIf.busGnt && (busIf.ramIn || busIf.ramOut)) gntViol++;
    if (busIf.busReq) begin
      if (busReqFirst < 0) busReqFirst = cycleNo;
      busReqLast = cycleNo;
    end
    if (busIf.ramIn) begin
      if (bus !== busIf.wrData) busDataViol++;
      mem[busIf.addressOut] = bus;
      wrAddrLog.push_back(busIf.addressOut);
      ramInCount++;
      if (ramInFirst < 0) ramInFirst = cycleNo;
      ramInLast = cycleNo;
      if (ramInCount == gntDropAfter) gntStallLeft = gntDropLen;
    end
    if (busIf.ramOut) begin
      rdAddrLog.push_back(busIf.addressOut);
      ramOutCount++;
      if (ramOutFirst < 0) ramOutFirst = cycleNo;
    end
    if (busIf.rdValid && rdValidFirst < 0) rdValidFirst = cycleNo;
    if (busIf.err) errCount++;
    wrTake  = busIf.wrValid && busIf.wrReady;
    rdTake  = busIf.rdValid && busIf.rdReady;
    reqTake = busIf.reqValid && busIf.reqReady;
    if (rdTake) begin
      rdGot.push_back(busIf.rdData);
      if (rdTakeFirst < 0) rdTakeFirst = cycleNo;
      rdTakeLast = cycleNo;
      if (rdGot.size() == 1) rdStallLeft = rdStallArm;
    end
    if (reqTake) begin
      reqTakenFlag = 1'b1;
      acceptCycle  = cycleNo;
    end
    @(posedge clk);
    #1;
    cycleNo++;
    if (wrTake && wrQueue.size() > 0) void'(wrQueue.pop_front());
    if (reqTake) busIf.reqValid = 1'b0;
    driveStreams();
  endtask

  task automatic runBurst(input bit wr, input logic [ADDR_W-1:0] addr,
                          input logic [LEN_W-1:0] len, input bit fixedData,
                          input logic [DATA_W-1:0] dataBase, input string name);
    int                n;
    int                after;
    int                budget;
    bit                rejected;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] expAddr[$];
    logic [DATA_W-1:0] expRd[$];
    n = int'(len) + 1;
`ifdef RAM_BUS_MASTER_WRAP_EN
    rejected = 1'b0;
`else
    rejected = (int'(addr) + int'(len)) > (RAM_DEPTH - 1);
`endif
    clearLogs();
    for (int i = 0; i < n; i++) begin
      a = ADDR_W'((int'(addr) + i) % RAM_DEPTH);
      if (!rejected) expAddr.push_back(a);
      if (wr) begin
        d = fixedData ? (dataBase + DATA_W'(i)) : DATA_W'($urandom);
        wrQueue.push_back(d);
        if (!rejected) refMem[a] = d;
      end else if (!rejected) begin
        expRd.push_back(refMem[a]);
      end
    end
    busIf.reqWrite = wr;
    busIf.reqAddr  = addr;
    busIf.reqLen   = len;
    busIf.reqValid = 1'b1;
    driveStreams();
    after  = 0;
    budget = 0;
    while (budget < 600) begin
      stepCycle();
      budget++;
      if (reqTakenFlag) after++;
      if (after >= 2 && !busIf.busy && rdGot.size() >= expRd.size() &&
          (!wr || rejected || wrQueue.size() == 0)) break;
    end
    checkOutput({name, ".timeout"}, 32'(budget >= 600), 32'(0));
    busIf.reqValid = 1'b0;
    wrQueue.delete();
    driveStreams();
    checkOutput({name, ".busReqAfter"}, 32'(busIf.busReq), 32'(0));
    if (rejected) begin
      checkOutput({name, ".errPulses"}, 32'(errCount), 32'(1));
      checkOutput({name, ".noRamIn"}, 32'(ramInCount), 32'(0));
      checkOutput({name, ".noRamOut"}, 32'(ramOutCount), 32'(0));
      checkOutput({name, ".noBusReq"}, 32'(busReqFirst), 32'(-1));
    end else begin
      checkOutput({name, ".noErr"}, 32'(errCount), 32'(0));
      if (wr) begin
        checkOutput({name, ".ramInCount"}, 32'(ramInCount), 32'(n));
        checkOutput({name, ".noRamOut"}, 32'(ramOutCount), 32'(0));
        for (int i = 0; i < n; i++) begin
          checkOutput($sformatf("%s.wrAddr%0d", name, i),
                      (i < wrAddrLog.size()) ? 32'(wrAddrLog[i]) : 32'hFFFF_FFFF,
                      32'(expAddr[i]));
          checkOutput($sformatf("%s.memWord%0d", name, i),
                      32'(mem[expAddr[i]]), 32'(refMem[expAddr[i]]));
        end
      end else begin
        checkOutput({name, ".ramOutCount"}, 32'(ramOutCount), 32'(n));
        checkOutput({name, ".noRamIn"}, 32'(ramInCount), 32'(0));
        checkOutput({name, ".rdWords"}, 32'(rdGot.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
          checkOutput($sformatf("%s.rdAddr%0d", name, i),
                      (i < rdAddrLog.size()) ? 32'(rdAddrLog[i]) : 32'hFFFF_FFFF,
                      32'(expAddr[i]));
          checkOutput($sformatf("%s.rdData%0d", name, i),
                      (i < rdGot.size()) ? 32'(rdGot[i]) : 32'hFFFF_FFFF,
                      32'(expRd[i]));
        end
      end
    end
    checkOutput({name, ".strobeOverlap"}, 32'(overlapViol), 32'(0));
    checkOutput({name, ".busHiZ"}, 32'(hizViol), 32'(0));
    checkOutput({name, ".busWrData"}, 32'(busDataViol), 32'(0));
    checkOutput({name, ".beatWithoutGnt"}, 32'(gntViol), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected the test to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : applyStimulus
    logic [DATA_W-1:0] wd [5];
    int                guard;
    int                memMismatch;

    rst_n          = 1'b0;
    busIf.reqValid = 1'b0;
    busIf.reqWrite = 1'b0;
    busIf.reqAddr  = '0;
    busIf.reqLen   = '0;
    busIf.wrValid  = 1'b0;
    busIf.wrData   = 16'hFFFF;
    busIf.rdReady  = 1'b0;
    busIf.busGnt   = 1'b0;
    wrRandom       = 1'b0;
    rdRandom       = 1'b0;
    gntRandom      = 1'b0;
    rdStallArm     = 0;
    gntDropAfter   = 0;
    gntDropLen     = 0;
    clearLogs();
    for (int i = 0; i < RAM_DEPTH; i++) begin
      mem[i]    = DATA_W'($urandom);
      refMem[i] = mem[i];
    end

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.busReq", 32'(busIf.busReq), 32'(0));
    checkOutput("rst.ramIn", 32'(busIf.ramIn), 32'(0));
    checkOutput("rst.ramOut", 32'(busIf.ramOut), 32'(0));
    checkOutput("rst.wrReady", 32'(busIf.wrReady), 32'(0));
    checkOutput("rst.rdValid", 32'(busIf.rdValid), 32'(0));
    checkOutput("rst.busy", 32'(busIf.busy), 32'(0));
    checkOutput("rst.err", 32'(busIf.err), 32'(0));
    checkOutput("rst.addressOut", 32'(busIf.addressOut), 32'(0));
    checkOutput("rst.rdData", 32'(busIf.rdData), 32'(0));
    checkOutput("rst.busHiZ", 32'(bus), 32'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst.reqReady", 32'(busIf.reqReady), 32'(1));

    // single-word write and read: cycle-exact latency
    runBurst(1'b1, 8'h20, 4'd0, 1'b1, 16'h1234, "wr1");
    checkOutput("wr1.busReqRel", 32'(busReqFirst - acceptCycle), 32'(1));
    checkOutput("wr1.ramInRel", 32'(ramInFirst - acceptCycle), 32'(2));
    checkOutput("wr1.busReqLastRel", 32'(busReqLast - acceptCycle), 32'(2));
    runBurst(1'b0, 8'h20, 4'd0, 1'b0, 16'h0, "rd1");
    checkOutput("rd1.ramOutRel", 32'(ramOutFirst - acceptCycle), 32'(2));
    checkOutput("rd1.rdValidRel", 32'(rdValidFirst - acceptCycle), 32'(3));
    checkOutput("rd1.word", (rdGot.size() > 0) ? 32'(rdGot[0]) : 32'hFFFF_FFFF, 32'h1234);

    // write burst of 4 then read it back at full rate
    runBurst(1'b1, 8'h10, 4'd3, 1'b1, 16'hA000, "wr4");
    checkOutput("wr4.consecutive", 32'(ramInLast - ramInFirst), 32'(3));
    checkOutput("wr4.busReqDrop", 32'(busReqLast), 32'(ramInLast));
    runBurst(1'b0, 8'h10, 4'd3, 1'b0, 16'h0, "rd4");
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rd4.fixed%0d", i),
                  (i < rdGot.size()) ? 32'(rdGot[i]) : 32'hFFFF_FFFF, 32'(16'hA000 + i));
    end
    checkOutput("rd4.consecutive", 32'(rdTakeLast - rdTakeFirst), 32'(3));

    // read burst of 3 with the consumer stalling after the first word
    rdStallArm = 2;
    runBurst(1'b0, 8'h11, 4'd2, 1'b0, 16'h0, "rdStall");
    rdStallArm = 0;
    checkOutput("rdStall.span", 32'(rdTakeLast - rdTakeFirst), 32'(4));

    // grant withdrawn for 3 cycles after beat 2 of a 5-word write
    gntDropAfter = 2;
    gntDropLen   = 3;
    runBurst(1'b1, 8'h30, 4'd4, 1'b0, 16'h0, "gntDrop");
    gntDropAfter = 0;
    gntDropLen   = 0;
    checkOutput("gntDrop.span", 32'(ramInLast - ramInFirst), 32'(7));

    // burst crossing the top of the RAM
    runBurst(1'b1, 8'hFE, 4'd3, 1'b0, 16'h0, "wrap");

    // reset asserted in the middle of a 5-word write
    clearLogs();
    for (int i = 0; i < 5; i++) begin
      wd[i] = DATA_W'($urandom);
      wrQueue.push_back(wd[i]);
    end
    busIf.reqWrite = 1'b1;
    busIf.reqAddr  = 8'h40;
    busIf.reqLen   = 4'd4;
    busIf.reqValid = 1'b1;
    driveStreams();
    guard = 0;
    while (ramInCount < 2 && guard < 100) begin
      stepCycle();
      guard++;
    end
    checkOutput("rstMid.reachedBeat", 32'(guard < 100), 32'(1));
    checkOutput("rstMid.ramInBefore", 32'(busIf.ramIn), 32'(1));
    refMem[8'h40] = wd[0];
    refMem[8'h41] = wd[1];
    rst_n = 1'b0;
    #1;
    checkOutput("rstMid.busHiZ", 32'(bus), 32'(0));
    checkOutput("rstMid.busReq", 32'(busIf.busReq), 32'(0));
    checkOutput("rstMid.ramIn", 32'(busIf.ramIn), 32'(0));
    checkOutput("rstMid.wrReady", 32'(busIf.wrReady), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wrQueue.delete();
    busIf.reqValid = 1'b0;
    driveStreams();
    @(posedge clk);
    #1;
    checkOutput("rstMid.busy", 32'(busIf.busy), 32'(0));
    checkOutput("rstMid.reqReady", 32'(busIf.reqReady), 32'(1));
    checkOutput("rstMid.rdValid", 32'(busIf.rdValid), 32'(0));

    // randomized bursts with random grant, write-valid and read-ready
    wrRandom  = 1'b1;
    rdRandom  = 1'b1;
    gntRandom = 1'b1;
    for (int k = 0; k < 25; k++) begin
      runBurst(1'($urandom_range(1)), ADDR_W'($urandom_range(RAM_DEPTH - 1)),
               LEN_W'($urandom_range(15)), 1'b0, 16'h0, $sformatf("rnd%0d", k));
    end

    memMismatch = 0;
    for (int i = 0; i < RAM_DEPTH; i++) begin
      if (mem[i] !== refMem[i]) memMismatch++;
    end
    checkOutput("memFinal", 32'(memMismatch), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
